mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port instruction/data memory between the core's instruction-fetch port (M0) and load/store port (M1).
- Grants one master per cycle and routes the 1-cycle-latency read response back to its owner.
- Raises a fetch-hold to the core while fetch is denied.
- Sits between top's fetch/LSU logic and the memory model instantiated by the bench.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_STREAK, 4, maximum consecutive M1 grants while M0 is waiting.
- PERF_W, 32, width of the performance counters (feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- m0_req_i  in  1  fetch request.
- m0_addr_i  in  ADDR_W  fetch address.
- m0_gnt_o  out  1  fetch granted this cycle.
- m0_rdata_o  out  DATA_W  fetch read data.
- m0_rvalid_o  out  1  fetch response valid.
- m1_req_i  in  1  LSU request.
- m1_we_i  in  1  LSU write enable.
- m1_be_i  in  DATA_W/8  LSU byte enables.
- m1_addr_i  in  ADDR_W  LSU address.
- m1_wdata_i  in  DATA_W  LSU write data.
- m1_gnt_o  out  1  LSU granted this cycle.
- m1_rdata_o  out  DATA_W  LSU read data.
- m1_rvalid_o  out  1  LSU response valid.
- s_req_o  out  1  memory request.
- s_we_o  out  1  memory write enable.
- s_be_o  out  DATA_W/8  memory byte enables.
- s_addr_o  out  ADDR_W  memory address.
- s_wdata_o  out  DATA_W  memory write data.
- s_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after an accepted read.
- hold_if_o  out  1  stall the PC; high when m0_req_i && !m0_gnt_o.

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, streak=0, resp_owner=NONE. All gnt, rvalid and s_req outputs are 0; rdata outputs are 0.
- Grant is combinational in the cycle of the request. The memory always accepts, so gnt implies acceptance that cycle. Requests are level-held by the master until granted.
- Priority: M1 beats M0, except when streak==MAX_STREAK and m0_req_i is high, in which case M0 wins.
- streak:
  - Increments on an M1 grant while m0_req_i is high.
  - Clears on an M0 grant or when m0_req_i is low.
  - Saturates at MAX_STREAK.
- s_* mux:
  - M0 grant: s_we_o=0, s_be_o=all ones.
  - No grant: s_req_o=0 and the other s_* signals hold 0.
- Response pipe, resp_owner register:
  - Set to M0, M1 or NONE at each edge from the current cycle's read grant. Writes set NONE.
  - Next cycle: rvalid of the owner=1 and its rdata=s_rdata_i. The non-owner's rdata=0.
- Back-to-back grants are fully pipelined: throughput is 1 per cycle and the response for cycle N appears in N+1 while cycle N+1's grant proceeds.
- State machine (registered, diagnostic and arbitration-visible):
  - IDLE: no grant.
  - FETCH: last grant M0.
  - DATA: last grant M1.
  - STARVE: streak==MAX_STREAK with M0 pending.
  - STARVE always transitions to FETCH on the next grant.
- Boundary conditions:
  - MAX_STREAK=0: M0 always wins (fetch priority).
  - Simultaneous M1 write and M0 read: M1 is granted, M0 is held, hold_if_o=1.
  - Reset mid-response: rvalid is suppressed the next cycle and the pending response is dropped.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict_o [PERF_W] and perf_starve_o [PERF_W].
  - perf_conflict_o counts cycles with both requests high.
  - perf_starve_o counts forced M0 grants.
  - Both are zero on reset and wrap at 2^PERF_W.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines header: owner encodings (OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2) and state encodings (IDLE/FETCH/DATA/STARVE).
- One natural sub-module, arb_resp_pipe: the resp_owner register plus rdata/rvalid demux.

Test Plan:
- M0 alone, addr 0,4,8,12, memory returns 0x00100513 etc. -> m0_gnt_o=1 each cycle, m0_rvalid_o one cycle later with matching data, hold_if_o=0.
- M1 read at 0x100 concurrent with M0 at 0x4 -> m1_gnt_o=1, hold_if_o=1; next cycle m1_rvalid_o=1 with m1_rdata_o=mem[0x100]; M0 is granted the following cycle.
- M1 held high 8 cycles with M0 pending, MAX_STREAK=4 -> grants M1×4, M0×1, M1×3; M0 sees no more than 4 stall cycles.
- M1 write 0xDEADBEEF, be=4'b0011 -> s_we_o=1, s_be_o=0011, no rvalid next cycle on either port.
- rst driven low during an outstanding M0 read -> next cycle m0_rvalid_o=0, all outputs 0, streak=0.
- With ARB_PERF_CNT_EN, 6 conflict cycles including 1 forced M0 grant -> perf_conflict_o=6, perf_starve_o=1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared owner and arbiter-state encodings for mem_bus_arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DATA   = 2'd2,
        STARVE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch/LSU/memory bus bundle; ARB_PERF_CNT_EN adds perf counter outputs
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
);
    logic                m0_req_i;
    logic [ADDR_W-1:0]   m0_addr_i;
    logic                m0_gnt_o;
    logic [DATA_W-1:0]   m0_rdata_o;
    logic                m0_rvalid_o;
    logic                m1_req_i;
    logic                m1_we_i;
    logic [DATA_W/8-1:0] m1_be_i;
    logic [ADDR_W-1:0]   m1_addr_i;
    logic [DATA_W-1:0]   m1_wdata_i;
    logic                m1_gnt_o;
    logic [DATA_W-1:0]   m1_rdata_o;
    logic                m1_rvalid_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [DATA_W/8-1:0] s_be_o;
    logic [ADDR_W-1:0]   s_addr_o;
    logic [DATA_W-1:0]   s_wdata_o;
    logic [DATA_W-1:0]   s_rdata_i;
    logic                hold_if_o;
    arb_state_e          arb_state_o;
`ifdef ARB_PERF_CNT_EN
    logic [PERF_W-1:0]   perf_conflict_o;
    logic [PERF_W-1:0]   perf_starve_o;
    modport slave (
        input  m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, s_rdata_i,
        output m0_gnt_o, m0_rdata_o, m0_rvalid_o, m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, hold_if_o, arb_state_o,
        output perf_conflict_o, perf_starve_o
    );
    modport master (
        output m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, s_rdata_i,
        input  m0_gnt_o, m0_rdata_o, m0_rvalid_o, m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, hold_if_o, arb_state_o,
        input  perf_conflict_o, perf_starve_o
    );
`else
    modport slave (
        input  m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, s_rdata_i,
        output m0_gnt_o, m0_rdata_o, m0_rvalid_o, m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, hold_if_o, arb_state_o
    );
    modport master (
        output m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, s_rdata_i,
        input  m0_gnt_o, m0_rdata_o, m0_rvalid_o, m1_gnt_o, m1_rdata_o, m1_rvalid_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, hold_if_o, arb_state_o
    );
`endif
endinterface

// File: rtl/arb_resp_pipe.sv
// arb_resp_pipe: remembers which master owns the in-flight read and steers the response to it
module arb_resp_pipe
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  owner_e            owner_d,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid
);
    owner_e owner;
    // capture this cycle's read owner; reset drops any pending response
    always_ff @(posedge clk)
        owner <= !rst ? OWN_NONE : owner_d;
    // only the owner sees valid data, the other port reads zero
    always_comb begin
        m0_rvalid = owner == OWN_M0;
        m1_rvalid = owner == OWN_M1;
        m0_rdata  = m0_rvalid ? s_rdata : '0;
        m1_rdata  = m1_rvalid ? s_rdata : '0;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fetch/LSU arbiter for one single-port memory; ARB_PERF_CNT_EN adds perf counters
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.slave  bus
);
    localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);
    logic [SW-1:0] streak, streak_d;
    arb_state_e    state, state_d;
    owner_e        owner_d;
    logic          starve, gnt0, gnt1;
    // grant decision, streak/state next values and response owner for this cycle
    always_comb begin
        starve   = bus.m0_req_i && (streak == SMAX);
        gnt0     = rst && bus.m0_req_i && (!bus.m1_req_i || starve);
        gnt1     = rst && bus.m1_req_i && !gnt0;
        streak_d = (!bus.m0_req_i || gnt0) ? '0 : (gnt1 && streak != SMAX) ? streak + 1'b1 : streak;
        owner_d  = gnt0 ? OWN_M0 : (gnt1 && !bus.m1_we_i) ? OWN_M1 : OWN_NONE;
        state_d  = gnt0 ? FETCH : !gnt1 ? IDLE : (bus.m0_req_i && streak_d == SMAX) ? STARVE : DATA;
    end
    // arbitration state and streak registers
    always_ff @(posedge clk)
        if (!rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_d;
            streak <= streak_d;
        end
    // grant outputs and memory-side mux; idle bus drives all zeros
    always_comb begin
        bus.m0_gnt_o    = gnt0;
        bus.m1_gnt_o    = gnt1;
        bus.hold_if_o   = bus.m0_req_i && !gnt0;
        bus.s_req_o     = gnt0 || gnt1;
        bus.s_we_o      = gnt1 && bus.m1_we_i;
        bus.s_be_o      = gnt0 ? '1 : gnt1 ? bus.m1_be_i : '0;
        bus.s_addr_o    = gnt0 ? bus.m0_addr_i : gnt1 ? bus.m1_addr_i : '0;
        bus.s_wdata_o   = gnt1 ? bus.m1_wdata_i : '0;
        bus.arb_state_o = state;
    end
    arb_resp_pipe #(.DATA_W(DATA_W)) u_resp (
        .clk       (clk),
        .rst       (rst),
        .owner_d   (owner_d),
        .s_rdata   (bus.s_rdata_i),
        .m0_rdata  (bus.m0_rdata_o),
        .m0_rvalid (bus.m0_rvalid_o),
        .m1_rdata  (bus.m1_rdata_o),
        .m1_rvalid (bus.m1_rvalid_o)
    );
`ifdef ARB_PERF_CNT_EN
    // conflict cycles and forced fetch grants, free-running and wrapping
    always_ff @(posedge clk)
        if (!rst) begin
            bus.perf_conflict_o <= '0;
            bus.perf_starve_o   <= '0;
        end else begin
            if (bus.m0_req_i && bus.m1_req_i) bus.perf_conflict_o <= bus.perf_conflict_o + 1'b1;
            if (gnt0 && bus.m1_req_i) bus.perf_starve_o <= bus.perf_starve_o + 1'b1;
        end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter (MAX_STREAK=4 and 0)
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [0:255];
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_bus_arbiter #(.DATA_W(32), .MAX_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_bus_arbiter #(.DATA_W(32), .MAX_STREAK(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    assign bus0.m0_req_i  = bus.m0_req_i;
    assign bus0.m0_addr_i = bus.m0_addr_i;
    assign bus0.m1_req_i  = bus.m1_req_i;
    assign bus0.m1_we_i   = bus.m1_we_i;
    assign bus0.m1_be_i   = bus.m1_be_i;
    assign bus0.m1_addr_i = bus.m1_addr_i;
    assign bus0.m1_wdata_i = bus.m1_wdata_i;
    assign bus0.s_rdata_i = bus.s_rdata_i;
    always #5 clk = ~clk;
    // memory model: 1-cycle read latency, byte-enabled writes, contents loaded during reset
    always @(posedge clk) begin
        if (!rst) begin
            mem[0]    <= 32'h00100513;
            mem[1]    <= 32'h00200593;
            mem[2]    <= 32'h00300613;
            mem[3]    <= 32'h00400693;
            mem[8'h40] <= 32'hCAFEF00D;
            mem[8'h41] <= 32'h11111111;
            mem[8'h42] <= 32'h12345678;
        end else if (bus.s_req_o && bus.s_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.s_be_o[b]) mem[bus.s_addr_o[9:2]][8*b +: 8] <= bus.s_wdata_o[8*b +: 8];
        end
        if (bus.s_req_o && !bus.s_we_o) bus.s_rdata_i <= mem[bus.s_addr_o[9:2]];
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b0;
        bus.m0_req_i = 1'b1;
        bus.m1_req_i = 1'b1;
        repeat (2) cyc();
        checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.s_req_o} !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", {bus.m0_gnt_o, bus.m1_gnt_o, bus.s_req_o}); end
        checks++; if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_rdata_o, bus.m1_rdata_o} !== 66'd0) begin errors++; $display("FAIL reset_resp: got %h want 0", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_rdata_o, bus.m1_rdata_o}); end
        checks++; if (bus.arb_state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.arb_state_o, IDLE); end
        checks++; if (bus.s_addr_o !== 32'd0) begin errors++; $display("FAIL reset_saddr: got %h want 0", bus.s_addr_o); end
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        rst = 1'b1;
        cyc();
    endtask
    task automatic test_fetch;
        logic [31:0] exp [4];
        exp = '{32'h00100513, 32'h00200593, 32'h00300613, 32'h00400693};
        for (int i = 0; i < 4; i++) begin
            bus.m0_req_i = 1'b1;
            bus.m0_addr_i = 32'(4 * i);
            #1;
            checks++; if ({bus.m0_gnt_o, bus.hold_if_o, bus.s_req_o, bus.s_we_o, bus.s_be_o, bus.s_addr_o} !== {4'b1010, 4'hf, 32'(4 * i)}) begin errors++; $display("FAIL fetch_gnt[%0d]: got %h want %h", i, {bus.m0_gnt_o, bus.hold_if_o, bus.s_req_o, bus.s_we_o, bus.s_be_o, bus.s_addr_o}, {4'b1010, 4'hf, 32'(4 * i)}); end
            if (i > 0) begin
                checks++; if ({bus.m0_rvalid_o, bus.m0_rdata_o} !== {1'b1, exp[i-1]}) begin errors++; $display("FAIL fetch_resp[%0d]: got %h want %h", i, {bus.m0_rvalid_o, bus.m0_rdata_o}, {1'b1, exp[i-1]}); end
            end
            cyc();
        end
        bus.m0_req_i = 1'b0;
        #1;
        checks++; if ({bus.m0_rvalid_o, bus.m0_rdata_o, bus.m1_rvalid_o} !== {1'b1, exp[3], 1'b0}) begin errors++; $display("FAIL fetch_last: got %h want %h", {bus.m0_rvalid_o, bus.m0_rdata_o, bus.m1_rvalid_o}, {1'b1, exp[3], 1'b0}); end
        cyc();
    endtask
    task automatic test_conflict;
        bus.m0_req_i = 1'b1;
        bus.m0_addr_i = 32'h4;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b0;
        bus.m1_be_i = 4'hf;
        bus.m1_addr_i = 32'h100;
        #1;
        checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o, bus.hold_if_o, bus.s_addr_o} !== {3'b101, 32'h100}) begin errors++; $display("FAIL conflict_gnt: got %h want %h", {bus.m1_gnt_o, bus.m0_gnt_o, bus.hold_if_o, bus.s_addr_o}, {3'b101, 32'h100}); end
        checks++; if ({bus0.m0_gnt_o, bus0.m1_gnt_o, bus0.hold_if_o} !== 3'b100) begin errors++; $display("FAIL fetch_priority: got %b want 100", {bus0.m0_gnt_o, bus0.m1_gnt_o, bus0.hold_if_o}); end
        cyc();
        bus.m1_req_i = 1'b0;
        #1;
        checks++; if ({bus.m1_rvalid_o, bus.m1_rdata_o, bus.m0_rvalid_o, bus.m0_rdata_o} !== {1'b1, 32'hCAFEF00D, 1'b0, 32'd0}) begin errors++; $display("FAIL conflict_resp: got %h want %h", {bus.m1_rvalid_o, bus.m1_rdata_o, bus.m0_rvalid_o, bus.m0_rdata_o}, {1'b1, 32'hCAFEF00D, 1'b0, 32'd0}); end
        checks++; if ({bus.m0_gnt_o, bus.hold_if_o, bus.s_addr_o} !== {2'b10, 32'h4}) begin errors++; $display("FAIL conflict_m0_next: got %h want %h", {bus.m0_gnt_o, bus.hold_if_o, bus.s_addr_o}, {2'b10, 32'h4}); end
        checks++; if (bus.arb_state_o !== DATA) begin errors++; $display("FAIL state_data: got %0d want %0d", bus.arb_state_o, DATA); end
        cyc();
        bus.m0_req_i = 1'b0;
        #1;
        checks++; if ({bus.m0_rvalid_o, bus.m0_rdata_o} !== {1'b1, 32'h00200593}) begin errors++; $display("FAIL conflict_m0_resp: got %h want %h", {bus.m0_rvalid_o, bus.m0_rdata_o}, {1'b1, 32'h00200593}); end
        checks++; if (bus.arb_state_o !== FETCH) begin errors++; $display("FAIL state_fetch: got %0d want %0d", bus.arb_state_o, FETCH); end
        cyc();
    endtask
    task automatic test_starve;
        logic [7:0] pat;
        pat = 8'b11101111;
        bus.m0_req_i = 1'b1;
        bus.m0_addr_i = 32'h8;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b0;
        bus.m1_addr_i = 32'h104;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if ({bus.m1_gnt_o, bus.m0_gnt_o, bus.hold_if_o} !== {pat[i], !pat[i], pat[i]}) begin errors++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {bus.m1_gnt_o, bus.m0_gnt_o, bus.hold_if_o}, {pat[i], !pat[i], pat[i]}); end
            if (i == 4) begin
                checks++; if (bus.arb_state_o !== STARVE) begin errors++; $display("FAIL state_starve: got %0d want %0d", bus.arb_state_o, STARVE); end
            end
            if (i == 5) begin
                checks++; if ({bus.m0_rvalid_o, bus.m0_rdata_o} !== {1'b1, 32'h00300613}) begin errors++; $display("FAIL starve_m0_resp: got %h want %h", {bus.m0_rvalid_o, bus.m0_rdata_o}, {1'b1, 32'h00300613}); end
            end
            if (i == 6) begin
                checks++; if ({bus.m1_rvalid_o, bus.m1_rdata_o, bus.m0_rvalid_o} !== {1'b1, 32'h11111111, 1'b0}) begin errors++; $display("FAIL starve_m1_resp: got %h want %h", {bus.m1_rvalid_o, bus.m1_rdata_o, bus.m0_rvalid_o}, {1'b1, 32'h11111111, 1'b0}); end
            end
            cyc();
        end
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        #1;
        checks++; if (bus.arb_state_o !== DATA) begin errors++; $display("FAIL starve_end_state: got %0d want %0d", bus.arb_state_o, DATA); end
        cyc();
    endtask
    task automatic test_write;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b1;
        bus.m1_be_i = 4'b0011;
        bus.m1_addr_i = 32'h108;
        bus.m1_wdata_i = 32'hDEADBEEF;
        #1;
        checks++; if ({bus.m1_gnt_o, bus.s_req_o, bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o} !== {3'b111, 4'b0011, 32'h108, 32'hDEADBEEF}) begin errors++; $display("FAIL write_bus: got %h want %h", {bus.m1_gnt_o, bus.s_req_o, bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o}, {3'b111, 4'b0011, 32'h108, 32'hDEADBEEF}); end
        cyc();
        bus.m1_we_i = 1'b0;
        bus.m1_be_i = 4'hf;
        #1;
        checks++; if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00) begin errors++; $display("FAIL write_no_rvalid: got %b want 00", {bus.m1_rvalid_o, bus.m0_rvalid_o}); end
        checks++; if ({bus.m1_gnt_o, bus.s_we_o, bus.s_be_o} !== {2'b10, 4'hf}) begin errors++; $display("FAIL readback_bus: got %b want %b", {bus.m1_gnt_o, bus.s_we_o, bus.s_be_o}, {2'b10, 4'hf}); end
        cyc();
        bus.m1_req_i = 1'b0;
        #1;
        checks++; if ({bus.m1_rvalid_o, bus.m1_rdata_o} !== {1'b1, 32'h1234BEEF}) begin errors++; $display("FAIL readback_data: got %h want %h", {bus.m1_rvalid_o, bus.m1_rdata_o}, {1'b1, 32'h1234BEEF}); end
        cyc();
    endtask
    task automatic test_reset_mid;
        bus.m0_req_i = 1'b1;
        bus.m0_addr_i = 32'hc;
        #1;
        checks++; if (bus.m0_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", bus.m0_gnt_o); end
        rst = 1'b0;
        cyc();
        checks++; if ({bus.m0_rvalid_o, bus.m0_rdata_o, bus.m1_rvalid_o, bus.m1_rdata_o} !== 66'd0) begin errors++; $display("FAIL rmid_resp: got %h want 0", {bus.m0_rvalid_o, bus.m0_rdata_o, bus.m1_rvalid_o, bus.m1_rdata_o}); end
        checks++; if ({bus.m0_gnt_o, bus.m1_gnt_o, bus.s_req_o} !== 3'b000) begin errors++; $display("FAIL rmid_gnt_low: got %b want 000", {bus.m0_gnt_o, bus.m1_gnt_o, bus.s_req_o}); end
        checks++; if (bus.arb_state_o !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d want %0d", bus.arb_state_o, IDLE); end
        rst = 1'b1;
        bus.m0_addr_i = 32'h0;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b0;
        bus.m1_addr_i = 32'h100;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.m1_gnt_o !== (i < 4)) begin errors++; $display("FAIL rmid_streak[%0d]: got %b want %b", i, bus.m1_gnt_o, (i < 4)); end
            cyc();
        end
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        cyc();
    endtask
`ifdef ARB_PERF_CNT_EN
    task automatic test_perf;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        checks++; if ({bus.perf_conflict_o, bus.perf_starve_o} !== 64'd0) begin errors++; $display("FAIL perf_reset: got %h want 0", {bus.perf_conflict_o, bus.perf_starve_o}); end
        bus.m0_req_i = 1'b1;
        bus.m1_req_i = 1'b1;
        repeat (6) cyc();
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        #1;
        checks++; if (bus.perf_conflict_o !== 32'd6) begin errors++; $display("FAIL perf_conflict: got %0d want 6", bus.perf_conflict_o); end
        checks++; if (bus.perf_starve_o !== 32'd1) begin errors++; $display("FAIL perf_starve: got %0d want 1", bus.perf_starve_o); end
        cyc();
    endtask
`endif
    initial begin
        rst = 1'b0;
        bus.m0_req_i = 1'b0;
        bus.m0_addr_i = '0;
        bus.m1_req_i = 1'b0;
        bus.m1_we_i = 1'b0;
        bus.m1_be_i = '0;
        bus.m1_addr_i = '0;
        bus.m1_wdata_i = '0;
        cyc();
        test_reset();
        test_fetch();
        test_conflict();
        test_starve();
        test_write();
        test_reset_mid();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
